// File: rtl/serial_shift_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_shift_unit_if
//  Description : SPI-slave pin bundle for serial_shift_unit (select, data, enable, busy).
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_shift_unit_if;
   logic i_nss;
   logic i_mosi;
   logic o_miso;
   logic o_miso_oe;
   logic o_busy;

   modport slave  (input  i_nss, i_mosi, output o_miso, o_miso_oe, o_busy);
   modport master (output i_nss, i_mosi, input  o_miso, o_miso_oe, o_busy);
endinterface
`default_nettype wire

// File: rtl/serial_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_shift_unit
//  Description : SPI-slave shift/rotate coprocessor; serial request in, one-cycle
//                op, serial result out. Optional macro SHIFT_STATUS_BIT_EN appends
//                an illegal-opcode status bit after the result.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_shift_unit #(
   parameter int DATA_WIDTH = 8
) (
   input  wire logic          i_clock,
   input  wire logic          i_reset,
   serial_shift_unit_if.slave bus
);
   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
   localparam int PACKET_BITS = 3 + DATA_WIDTH + SHAMT_WIDTH;
   localparam int CNT_WIDTH   = $clog2(PACKET_BITS + 1);
`ifdef SHIFT_STATUS_BIT_EN
   localparam int TX_BITS     = DATA_WIDTH + 1;
`else
   localparam int TX_BITS     = DATA_WIDTH;
`endif
   localparam logic [CNT_WIDTH-1:0] c_RX_LAST = CNT_WIDTH'(PACKET_BITS - 1);
   localparam logic [CNT_WIDTH-1:0] c_TX_LAST = CNT_WIDTH'(TX_BITS - 1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RECEIVE  = 3'd1,
      S_OPERATE  = 3'd2,
      S_READY    = 3'd3,
      S_TRANSMIT = 3'd4
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [CNT_WIDTH-1:0]     r_cnt;
   logic [PACKET_BITS-1:0]   r_packet;
   logic [DATA_WIDTH-1:0]    r_result;
   logic [TX_BITS-1:0]       r_txsh;
   logic                     w_miso;
   logic                     w_busy;

   logic [2:0]               w_opcode;
   logic [DATA_WIDTH-1:0]    w_operand;
   logic [SHAMT_WIDTH-1:0]   w_shamt;
   logic [DATA_WIDTH-1:0]    w_rol;
   logic [DATA_WIDTH-1:0]    w_ror;
   logic [DATA_WIDTH-1:0]    w_result;
   logic                     w_illegal;

   assign w_opcode  = r_packet[2:0];
   assign w_operand = r_packet[DATA_WIDTH+2:3];
   assign w_shamt   = r_packet[PACKET_BITS-1:PACKET_BITS-SHAMT_WIDTH];

   // Index arithmetic wraps mod DATA_WIDTH, so shamt=0 needs no special case.
   always_comb begin
      w_rol = '0;
      w_ror = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_rol[i] = w_operand[SHAMT_WIDTH'(i) - w_shamt];
         w_ror[i] = w_operand[SHAMT_WIDTH'(i) + w_shamt];
      end
   end

   always_comb begin
      w_result  = '0;
      w_illegal = 1'b0;
      case (w_opcode)
         3'b000:  w_result = w_operand << w_shamt;
         3'b001:  w_result = w_operand >> w_shamt;
         3'b010:  w_result = DATA_WIDTH'($signed(w_operand) >>> w_shamt);
         3'b011:  w_result = w_rol;
         3'b100:  w_result = w_ror;
         default: w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_miso = 1'b0;
      w_busy = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!bus.i_nss && bus.i_mosi) w_next = S_RECEIVE;
         end
         S_RECEIVE: begin
            w_busy = 1'b1;
            if (bus.i_nss)               w_next = S_IDLE;
            else if (r_cnt == c_RX_LAST) w_next = S_OPERATE;
         end
         S_OPERATE: begin
            w_busy = 1'b1;
            w_next = S_READY;
         end
         S_READY: begin
            w_miso = 1'b1;
            if (!bus.i_nss && !bus.i_mosi) w_next = S_TRANSMIT;
         end
         S_TRANSMIT: begin
            w_busy = 1'b1;
            w_miso = r_txsh[0];
            if (bus.i_nss)               w_next = S_IDLE;
            else if (r_cnt == c_TX_LAST) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.o_miso    = w_miso & ~bus.i_nss;
   assign bus.o_miso_oe = ~bus.i_nss;
   assign bus.o_busy    = w_busy;

`ifdef SHIFT_STATUS_BIT_EN
   logic r_illegal;
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)                 r_illegal <= 1'b0;
      else if (r_state == S_OPERATE) r_illegal <= w_illegal;
   end
`else
   logic w_illegal_unused;
   assign w_illegal_unused = w_illegal;
`endif

   // Packet arrives LSB first, so shifting in from the top leaves bit 0 at r_packet[0].
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt    <= '0;
         r_packet <= '0;
         r_result <= '0;
         r_txsh   <= '0;
      end else begin
         case (r_state)
            S_RECEIVE: begin
               if (bus.i_nss) begin
                  r_cnt <= '0;
               end else begin
                  r_packet <= {bus.i_mosi, r_packet[PACKET_BITS-1:1]};
                  r_cnt    <= (r_cnt == c_RX_LAST) ? '0 : r_cnt + c_CNT_ONE;
               end
            end
            S_OPERATE: begin
               r_result <= w_result;
               r_cnt    <= '0;
            end
            S_READY: begin
               r_cnt <= '0;
`ifdef SHIFT_STATUS_BIT_EN
               r_txsh <= {r_illegal, r_result};
`else
               r_txsh <= r_result;
`endif
            end
            S_TRANSMIT: begin
               if (bus.i_nss || r_cnt == c_TX_LAST) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt  <= r_cnt + c_CNT_ONE;
                  r_txsh <= r_txsh >> 1;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_serial_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_shift_unit
//  Description : Self-checking bench for serial_shift_unit; directed + random requests vs reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_shift_unit;
   localparam int DW = 8;
   localparam int SW = 3;
   localparam int PB = 3 + DW + SW;
`ifdef SHIFT_STATUS_BIT_EN
   localparam int TXB = DW + 1;
`else
   localparam int TXB = DW;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   serial_shift_unit_if bus();

   serial_shift_unit #(.DATA_WIDTH(DW)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: shifts as multiply/divide, rotates as repeated single-bit moves.
   function automatic int ref_op(input int op, input int a, input int s);
      int v;
      int r;
      r = 0;
      case (op)
         0: r = (a * (1 << s)) % (1 << DW);
         1: r = a / (1 << s);
         2: begin
            v = (a >= (1 << (DW - 1))) ? a - (1 << DW) : a;
            repeat (s) v = (v - (v & 1)) / 2;
            r = v & ((1 << DW) - 1);
         end
         3: begin
            r = a;
            repeat (s) r = ((r * 2) % (1 << DW)) + (r / (1 << (DW - 1)));
         end
         4: begin
            r = a;
            repeat (s) r = (r / 2) + (r % 2) * (1 << (DW - 1));
         end
         default: r = 0;
      endcase
      return r;
   endfunction

   task automatic send_to_ready(input int op, input int a, input int s);
      logic [PB-1:0] pkt;
      pkt = {s[SW-1:0], a[DW-1:0], op[2:0]};
      bus.i_nss  = 1'b0;
      bus.i_mosi = 1'b1;
      @(negedge clk);
      for (int i = 0; i < PB; i++) begin
         if (i == 0) check("busy_rx", {31'b0, bus.o_busy}, 32'd1);
         bus.i_mosi = pkt[i];
         @(negedge clk);
      end
      check("busy_op", {31'b0, bus.o_busy}, 32'd1);
      bus.i_mosi = 1'b1;
      @(negedge clk);
      check("ready_miso", {31'b0, bus.o_miso}, 32'd1);
      check("ready_busy", {31'b0, bus.o_busy}, 32'd0);
   endtask

   task automatic do_req(input string tag, input int op, input int a, input int s, input bit wait_hi);
      logic [TXB-1:0] got;
      int exp_word;
      send_to_ready(op, a, s);
      if (wait_hi) begin
         bus.i_nss = 1'b1;
         repeat (3) @(negedge clk);
         check("wait_oe", {31'b0, bus.o_miso_oe}, 32'd0);
         check("wait_miso", {31'b0, bus.o_miso}, 32'd0);
         bus.i_nss = 1'b0;
         #1;
         check("wait_ready", {31'b0, bus.o_miso}, 32'd1);
         @(negedge clk);
      end
      bus.i_mosi = 1'b0;
      @(negedge clk);
      got = '0;
      for (int b = 0; b < TXB; b++) begin
         if (b == 0) check("busy_tx", {31'b0, bus.o_busy}, 32'd1);
         got[b] = bus.o_miso;
         @(negedge clk);
      end
      check("busy_done", {31'b0, bus.o_busy}, 32'd0);
      check("idle_miso", {31'b0, bus.o_miso}, 32'd0);
      exp_word = ref_op(op, a, s);
`ifdef SHIFT_STATUS_BIT_EN
      if (op > 4) exp_word = exp_word | (1 << DW);
`endif
      check(tag, 32'(got), exp_word);
      bus.i_nss = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.i_nss  = 1'b1;
      bus.i_mosi = 1'b0;
      #2;
      check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
      check("rst_miso", {31'b0, bus.o_miso}, 32'd0);
      check("rst_oe_hi", {31'b0, bus.o_miso_oe}, 32'd0);
      bus.i_nss = 1'b0;
      #1;
      check("rst_oe_lo", {31'b0, bus.o_miso_oe}, 32'd1);
      check("rst_miso2", {31'b0, bus.o_miso}, 32'd0);
      bus.i_nss = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_req("sll_96_3", 0, 'h96, 3, 1'b0);
      do_req("ror_96_1", 4, 'h96, 1, 1'b1);
      do_req("sra_96_2", 2, 'h96, 2, 1'b0);
      do_req("srl_96_2", 1, 'h96, 2, 1'b0);
      do_req("rol_5a_0", 3, 'h5A, 0, 1'b0);
      do_req("sll_01_7", 0, 'h01, 7, 1'b0);
      do_req("ill_ff",   7, 'hFF, 5, 1'b0);

      // abort mid-request
      bus.i_nss  = 1'b0;
      bus.i_mosi = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         bus.i_mosi = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      bus.i_nss = 1'b1;
      @(negedge clk);
      check("abort_idle", {31'b0, bus.o_busy}, 32'd0);
      bus.i_mosi = 1'b1;
      repeat (3) @(negedge clk);
      check("nss_hi_nostart", {31'b0, bus.o_busy}, 32'd0);
      bus.i_mosi = 1'b0;
      do_req("srl_80_7", 1, 'h80, 7, 1'b0);

      // reset during TRANSMIT bit 3
      send_to_ready(0, 'h96, 3);
      bus.i_mosi = 1'b0;
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_miso", {31'b0, bus.o_miso}, 32'd0);
      check("rstmid_busy", {31'b0, bus.o_busy}, 32'd0);
      @(negedge clk);
      bus.i_nss = 1'b1;
      rst_n     = 1'b1;
      @(negedge clk);
      do_req("post_rst", 4, 'h3C, 2, 1'b0);

      for (int k = 0; k < 40; k++) begin
         do_req("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
